// File: rtl/dancepad_uart_tx_if.sv
// rtl/dancepad_uart_tx_if.sv - pad input and UART/status outputs of the dancepad transmitter
`timescale 1ns/1ps
interface dancepad_uart_tx_if;
  logic [7:0] pad;
  logic       TxD;
  logic       busy;
  logic [7:0] pad_state;

  modport master (output pad, input TxD, input busy, input pad_state);
  modport slave  (input pad, output TxD, output busy, output pad_state);
endinterface

// File: rtl/dancepad_uart_tx.sv
// rtl/dancepad_uart_tx.sv - debounced 8-pad sampler sending its state as 8N1 UART frames
`timescale 1ns/1ps
module dancepad_uart_tx #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int BAUD            = 9600,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REFRESH_CYCLES  = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  dancepad_uart_tx_if.slave bus_if
);
  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int BW = $clog2(BIT_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]    sync1_q, sync2_q;
  logic [DW-1:0] cnt_q [8];
  logic [DW-1:0] cnt_d [8];
  logic [7:0]    pad_q, pad_d;
  logic [RW-1:0] ref_q, ref_d;
  logic          pending_q, pending_d;
  state_e        fsm_q, fsm_d;
  logic [BW-1:0] base_q, base_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic          load, toggle, refresh_hit, base_end;

  // Per-bit debounce: a mismatch must persist DEBOUNCE_CYCLES samples to flip the level.
  always_comb begin
    pad_d = pad_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != pad_q[i]) begin
        if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          pad_d[i] = ~pad_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign toggle      = (pad_d != pad_q);
  assign refresh_hit = (REFRESH_CYCLES != 0) && (ref_q == RW'(REFRESH_CYCLES));
  assign base_end    = (base_q == BW'(BIT_CYCLES - 1));

  // A refresh being served by this load must not re-arm itself; a toggle on the load edge must.
  assign pending_d = (pending_q & ~load) | toggle | (refresh_hit & ~load);

  always_comb begin
    ref_d = ref_q;
    if (load) begin
      ref_d = '0;
    end else if (ref_q != RW'(REFRESH_CYCLES)) begin
      ref_d = ref_q + 1'b1;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    base_d  = base_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = 1'b1;
    load    = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (pending_q) begin
          load    = 1'b1;
          shreg_d = pad_q;
          base_d  = '0;
          fsm_d   = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (base_end) begin
          base_d = '0;
          bit_d  = '0;
          fsm_d  = DATA;
        end else begin
          base_d = base_q + 1'b1;
        end
      end
      DATA: begin
        txd_d = shreg_q[bit_q];
        if (base_end) begin
          base_d = '0;
          if (bit_q == 3'd7) begin
            fsm_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          base_d = base_q + 1'b1;
        end
      end
      STOP: begin
        if (base_end) begin
          base_d = '0;
          fsm_d  = IDLE;
        end else begin
          base_d = base_q + 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pad_q     <= '0;
      ref_q     <= '0;
      pending_q <= 1'b0;
      fsm_q     <= IDLE;
      base_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      txd_q     <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= bus_if.pad;
      sync2_q   <= sync1_q;
      pad_q     <= pad_d;
      ref_q     <= ref_d;
      pending_q <= pending_d;
      fsm_q     <= fsm_d;
      base_q    <= base_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      txd_q     <= txd_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus_if.TxD       = txd_q;
  assign bus_if.busy      = (fsm_q != IDLE);
  assign bus_if.pad_state = pad_q;
endmodule

// File: tb/tb_dancepad_uart_tx.sv
// tb/tb_dancepad_uart_tx.sv - self-checking bench for dancepad_uart_tx
`timescale 1ns/1ps
module tb_dancepad_uart_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  dancepad_uart_tx_if bus0();
  dancepad_uart_tx_if bus1();

  dancepad_uart_tx #(.CLK_HZ(1000), .BAUD(100), .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(0))
    u_dut0 (.clk(clk), .rst(rst0), .bus_if(bus0));
  dancepad_uart_tx #(.CLK_HZ(1000), .BAUD(100), .DEBOUNCE_CYCLES(4), .REFRESH_CYCLES(300))
    u_dut1 (.clk(clk), .rst(rst1), .bus_if(bus1));

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [7:0] val;
    int         start;
    bit         ok;
  } frame_t;

  frame_t fq0[$];
  frame_t fq1[$];
  int     cyc = 0;

  logic [1:0] mon_txd, mon_rst;
  assign mon_txd = {bus1.TxD, bus0.TxD};
  assign mon_rst = {rst1, rst0};

  bit     inf [2];
  int     off [2];
  bit     prev[2];
  frame_t cur [2];

  // Line decoder: 10-cycle bits, sampled mid-bit, frame start stamped at first low sample.
  always @(negedge clk) begin
    cyc++;
    for (int c = 0; c < 2; c++) begin
      if (mon_rst[c] === 1'b1) begin
        inf[c] = 1'b0;
      end else if (!inf[c]) begin
        if (prev[c] && mon_txd[c] === 1'b0) begin
          inf[c] = 1'b1;
          off[c] = 0;
          cur[c].start = cyc;
          cur[c].val = '0;
          cur[c].ok = 1'b1;
        end
      end else begin
        off[c]++;
        if (off[c] == 5 && mon_txd[c] !== 1'b0) cur[c].ok = 1'b0;
        if (off[c] >= 15 && off[c] <= 85 && (off[c] - 15) % 10 == 0)
          cur[c].val[(off[c] - 15) / 10] = mon_txd[c];
        if (off[c] == 95 && mon_txd[c] !== 1'b1) cur[c].ok = 1'b0;
        if (off[c] == 99) begin
          inf[c] = 1'b0;
          if (c == 0) fq0.push_back(cur[c]);
          else fq1.push_back(cur[c]);
        end
      end
      prev[c] = (mon_txd[c] === 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fall(input int ch, input int limit, output bit found);
    bit p;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      p = (mon_txd[ch] === 1'b1);
      step(1);
      if (p && mon_txd[ch] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.pad = 8'h00; bus1.pad = 8'h00;
    step(2);
    n_checks++; if (bus0.TxD !== 1'b1) begin n_fails++; $display("FAIL reset_txd: got %b expected 1", bus0.TxD); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
    n_checks++; if (bus0.pad_state !== 8'h00) begin n_fails++; $display("FAIL reset_pad_state: got %h expected 00", bus0.pad_state); end
    rst0 = 1'b0; rst1 = 1'b0;
    step(2);
    bus0.pad = 8'hA5;
    wait_fall(0, 50, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL reset_pre_frame: got no start bit expected one within 50 cycles"); end
    step(40);
    n_checks++; if (bus0.busy !== 1'b1) begin n_fails++; $display("FAIL reset_mid_busy: got %b expected 1", bus0.busy); end
    rst0 = 1'b1;
    #1;
    n_checks++; if (bus0.TxD !== 1'b1) begin n_fails++; $display("FAIL reset_mid_txd: got %b expected 1", bus0.TxD); end
    n_checks++; if (bus0.busy !== 1'b0) begin n_fails++; $display("FAIL reset_mid_busy_low: got %b expected 0", bus0.busy); end
    n_checks++; if (bus0.pad_state !== 8'h00) begin n_fails++; $display("FAIL reset_mid_pad_state: got %h expected 00", bus0.pad_state); end
    bus0.pad = 8'h00;
    step(2);
    fq0.delete();
    rst0 = 1'b0;
    step(200);
    n_checks++; if (fq0.size() != 0) begin n_fails++; $display("FAIL reset_no_frame: got %0d frames expected 0", fq0.size()); end
  endtask

  task automatic test_single_press();
    int hi = 0;
    @(posedge clk); #1;
    fq0.delete();
    bus0.pad = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (bus0.busy === 1'b1) hi++;
      if (k == 5) begin
        n_checks++; if (bus0.pad_state !== 8'h00) begin n_fails++; $display("FAIL press_early: got %h expected 00", bus0.pad_state); end
      end
      if (k == 6) begin
        n_checks++; if (bus0.pad_state !== 8'h01) begin n_fails++; $display("FAIL press_latency: got %h expected 01", bus0.pad_state); end
        n_checks++; if (bus0.busy !== 1'b0) begin n_fails++; $display("FAIL press_busy_toggle: got %b expected 0", bus0.busy); end
      end
      if (k == 7) begin
        n_checks++; if (bus0.TxD !== 1'b1) begin n_fails++; $display("FAIL press_txd_load: got %b expected 1", bus0.TxD); end
      end
      if (k == 8) begin
        n_checks++; if (bus0.TxD !== 1'b0) begin n_fails++; $display("FAIL press_txd_start: got %b expected 0", bus0.TxD); end
      end
    end
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (bus0.busy === 1'b1) hi++;
      else break;
    end
    n_checks++; if (hi != 100) begin n_fails++; $display("FAIL press_busy_len: got %0d expected 100", hi); end
    step(5);
    n_checks++; if (fq0.size() != 1) begin n_fails++; $display("FAIL press_frames: got %0d expected 1", fq0.size()); end
    else begin
      n_checks++; if (fq0[0].val !== 8'h01 || !fq0[0].ok) begin n_fails++; $display("FAIL press_data: got %h ok=%0d expected 01 ok=1", fq0[0].val, fq0[0].ok); end
    end
  endtask

  task automatic test_glitch();
    bit saw_low = 1'b0;
    bit changed = 1'b0;
    fq0.delete();
    bus0.pad = 8'h05;
    step(3);
    bus0.pad = 8'h01;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (bus0.TxD !== 1'b1) saw_low = 1'b1;
      if (bus0.pad_state !== 8'h01) changed = 1'b1;
    end
    n_checks++; if (changed) begin n_fails++; $display("FAIL glitch_state: got change expected pad_state stable 01"); end
    n_checks++; if (saw_low) begin n_fails++; $display("FAIL glitch_txd: got TxD low expected constant 1"); end
    n_checks++; if (fq0.size() != 0) begin n_fails++; $display("FAIL glitch_frames: got %0d expected 0", fq0.size()); end
  endtask

  task automatic test_coalesce();
    bit ok;
    bus0.pad = 8'h00;
    step(150);
    fq0.delete();
    bus0.pad = 8'h01;
    wait_fall(0, 30, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL coalesce_start: got no start bit expected one within 30 cycles"); end
    step(20); bus0.pad = 8'h09;
    step(15); bus0.pad = 8'h01;
    step(15); bus0.pad = 8'h05;
    for (int i = 0; i < 400 && fq0.size() < 2; i++) step(1);
    step(150);
    n_checks++; if (fq0.size() != 2) begin n_fails++; $display("FAIL coalesce_count: got %0d expected 2", fq0.size()); end
    else begin
      n_checks++; if (fq0[0].val !== 8'h01 || !fq0[0].ok) begin n_fails++; $display("FAIL coalesce_first: got %h expected 01", fq0[0].val); end
      n_checks++; if (fq0[1].val !== 8'h05 || !fq0[1].ok) begin n_fails++; $display("FAIL coalesce_second: got %h expected 05", fq0[1].val); end
      n_checks++; if (fq0[1].start - fq0[0].start != 101) begin n_fails++; $display("FAIL coalesce_gap: got %0d expected 101", fq0[1].start - fq0[0].start); end
    end
  endtask

  task automatic test_release();
    fq0.delete();
    bus0.pad = 8'h00;
    step(300);
    n_checks++; if (fq0.size() != 1) begin n_fails++; $display("FAIL release_count: got %0d expected 1", fq0.size()); end
    else begin
      n_checks++; if (fq0[0].val !== 8'h00 || !fq0[0].ok) begin n_fails++; $display("FAIL release_data: got %h expected 00", fq0[0].val); end
    end
  endtask

  // Model: a settled new value yields exactly one frame carrying it; short glitches and repeats yield none.
  task automatic test_random();
    logic [7:0] expq[$];
    logic [7:0] prev_v = 8'h00;
    logic [7:0] v, mask;
    fq0.delete();
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        mask = 8'($urandom_range(1, 255));
        bus0.pad = prev_v ^ mask;
        step($urandom_range(1, 3));
        bus0.pad = prev_v;
        step(6);
      end
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) v = prev_v;
      bus0.pad = v;
      step(130);
      if (v != prev_v) expq.push_back(v);
      prev_v = v;
    end
    n_checks++; if (fq0.size() != expq.size()) begin n_fails++; $display("FAIL random_count: got %0d expected %0d", fq0.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < fq0.size(); i++) begin
      n_checks++; if (fq0[i].val !== expq[i] || !fq0[i].ok) begin n_fails++; $display("FAIL random_frame%0d: got %h expected %h", i, fq0[i].val, expq[i]); end
    end
  endtask

  task automatic test_refresh();
    bit ok;
    bus1.pad = 8'h08;
    step(400);
    fq1.delete();
    step(302 * 3 + 120);
    n_checks++; if (fq1.size() < 3) begin n_fails++; $display("FAIL refresh_count: got %0d expected at least 3", fq1.size()); end
    for (int i = 0; i < fq1.size(); i++) begin
      n_checks++; if (fq1[i].val !== 8'h08 || !fq1[i].ok) begin n_fails++; $display("FAIL refresh_data%0d: got %h expected 08", i, fq1[i].val); end
      if (i > 0) begin
        n_checks++; if (fq1[i].start - fq1[i-1].start != 302) begin n_fails++; $display("FAIL refresh_period%0d: got %0d expected 302", i, fq1[i].start - fq1[i-1].start); end
      end
    end
    fq1.delete();
    wait_fall(1, 400, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL refresh_sync: got no start bit expected one within 400 cycles"); end
    // Debounced toggle lands on the edge where the saturated counter raises its request.
    step(294);
    bus1.pad = 8'h0C;
    step(300);
    n_checks++; if (fq1.size() != 2) begin n_fails++; $display("FAIL refresh_coincide_count: got %0d expected 2", fq1.size()); end
    else begin
      n_checks++; if (fq1[1].val !== 8'h0C || !fq1[1].ok) begin n_fails++; $display("FAIL refresh_coincide_data: got %h expected 0c", fq1[1].val); end
      n_checks++; if (fq1[1].start - fq1[0].start != 302) begin n_fails++; $display("FAIL refresh_coincide_gap: got %0d expected 302", fq1[1].start - fq1[0].start); end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_coalesce();
    test_release();
    test_random();
    test_refresh();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dancepad_uart_tx.md
# dancepad_uart_tx

Dancepad-side transmitter that samples eight raw pad switches, synchronizes and debounces them, and sends the debounced pad vector as 8N1 UART frames on `TxD`. `TxD` drives the control core's `RxD` line, where each received byte becomes the held event state. Frames go out on every debounced change and on a periodic refresh. A lost byte therefore never leaves a pad stuck pressed or released.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency.
- `BAUD`, 9600, line rate; `BIT_CYCLES = CLK_HZ / BAUD` (integer division, must be ≥ 2).
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable synchronized samples required to accept a new pad level (must be ≥ 1).
- `REFRESH_CYCLES`, 10_000_000, cycles from one frame start to a forced resend; 0 disables refresh.

- `clk`  in  1  system clock. One clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pad`  in  8  raw switch levels, asynchronous, 1 = pressed. Bit mapping: [0] up, [1] down, [2] left, [3] right, [7:4] auxiliary pads.
- `TxD`  out  1  UART line; idles high.
- `busy`  out  1  high while a frame is in START/DATA/STOP.
- `pad_state`  out  8  current debounced vector.

## Operation
- **Synchronizer:** two flops per `pad` bit giving `pad_sync`. No logic sits between the flops.
- **Debounce:** independent per bit.
  - Counter `cnt[i]` clears whenever `pad_sync[i] == pad_state[i]`.
  - Otherwise it increments.
  - When it reaches `DEBOUNCE_CYCLES`, `pad_state[i]` toggles and `cnt[i]` clears.
- **Send request:** `pending` is set in any cycle where any `pad_state` bit toggles, or where the refresh counter reaches `REFRESH_CYCLES`. Several causes in one cycle set `pending` once.
- **Refresh counter:**
  - Clears when a frame is loaded.
  - Otherwise it increments, saturating at `REFRESH_CYCLES`.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `TxD = 1`. If `pending` is set, latch `shreg <= pad_state` (the value current in that cycle), clear `pending`, clear the refresh counter, and go to START.
  - **START:** `TxD = 0` for `BIT_CYCLES` cycles, then go to DATA with `bit_idx = 0`.
  - **DATA:** `TxD = shreg[bit_idx]`, LSB first, each bit held `BIT_CYCLES` cycles. After `bit_idx = 7` go to STOP.
  - **STOP:** `TxD = 1` for `BIT_CYCLES` cycles, then return to IDLE.
- **Coalescing:** changes during a frame only set `pending`. The next frame carries the latest `pad_state` at load time, not intermediate values. A frame is never aborted except by `rst`.
- **Back-to-back frames:** if `pending` is set when STOP completes, IDLE lasts exactly one cycle (`TxD = 1`) before the next START.
- **Output decode:** `busy = (state != IDLE)`.
- **`TxD` register:** `TxD` is registered.

## Timing
- **Reset values (immediate, asynchronous):**
  - `TxD = 1`, `busy = 0`, `pad_state = 0`.
  - Synchronizers 0, all counters 0, `pending = 0`, state IDLE.
- **Reset mid-frame:** `TxD` returns high at once and the partial frame is dropped. No send is issued on reset release unless the debounce logic later toggles a bit.
- **Press to `pad_state`:** a clean `pad` edge appears on `pad_state` 2 + `DEBOUNCE_CYCLES` cycles later.
- **Load and frame latency:**
  - The `pad_state` toggle and `pending` set happen on the same edge.
  - The IDLE load happens on the next edge.
  - `TxD` falls (START) on the edge after the load.
  - Total from toggle edge to `TxD` low: 2 cycles when idle.
- **Frame length:** exactly `10 * BIT_CYCLES` cycles from `TxD` falling to STOP end.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles never changes `pad_state` and never sends.
- **Refresh:** while idle with no changes, frame starts are spaced exactly `REFRESH_CYCLES + 2` cycles apart (counter clears at load, one IDLE cycle after saturation).

## Test plan
All scenarios use `CLK_HZ = 1000`, `BAUD = 100` (`BIT_CYCLES = 10`), `DEBOUNCE_CYCLES = 4`, `REFRESH_CYCLES = 0` unless noted.
- **Reset state:** assert `rst` mid-DATA of a frame → `TxD = 1`, `busy = 0`, `pad_state = 0` in the same cycle; no frame after release with `pad = 0`.
- **Single press:** `pad = 8'h01` held → `pad_state = 01` after 6 cycles; `TxD` low 2 cycles later; bits decode as 0x01; STOP high; `busy` high for 100 cycles.
- **Glitch:** `pad[2]` high for 3 cycles → no `pad_state` change; `TxD` stays 1.
- **Coalescing:** press up, then during its frame press right, release right, press left (final `pad = 8'h05`, stable) → exactly two frames, 0x01 then 0x05, separated by one idle cycle.
- **Release:** after 0x05 is sent, `pad = 0` → one frame 0x00.
- **Refresh:** `REFRESH_CYCLES = 300`, `pad = 8'h08` stable → repeating 0x08 frames, starts exactly 302 cycles apart; a debounced change coinciding with saturation yields a single frame.
